shift_rotate_seq: RTL and testbench

- Parametrised successor to the fixed 8-bit mux / register / rotate datapath.
- Selects one of two operands, loads it, then runs a programmable number of single-bit shift or rotate steps in a chosen mode.
- Signals completion with busy/done flags.
- Sits between operand sources and downstream logic that samples q when done is high.

---
 rtl/shift_rotate_seq.sv | 168 ++++++++++++++++
 tb/tb_shift_rotate_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_seq.sv
// Operand select / load / multi-step shift-rotate sequencer with busy/done handshake.
// Optional macro SHIFT_CARRY_EN adds a carry output plus rotate-through-carry modes 110/111.
module shift_rotate_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  // state | meaning
  // IDLE  | no result held, waiting for start
  // RUN   | stepping q once per cycle, rem_q steps left
  // DONE  | result held in q until the next start
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] M_ROL = 3'b000;
  localparam logic [2:0] M_ROR = 3'b001;
  localparam logic [2:0] M_SLL = 3'b010;
  localparam logic [2:0] M_SRL = 3'b011;
  localparam logic [2:0] M_SRA = 3'b100;
  localparam logic [2:0] M_RCL = 3'b110;
  localparam logic [2:0] M_RCR = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
`ifdef SHIFT_CARRY_EN
  logic             carry_q, carry_d;
  logic             step_cy;
`endif

  // One single-bit step of q in the latched mode; unlisted modes hold.
  always_comb begin
    step_val = q_q;
`ifdef SHIFT_CARRY_EN
    step_cy  = carry_q;
`endif
    case (mode_q)
      M_ROL: begin
        step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`ifdef SHIFT_CARRY_EN
        step_cy  = q_q[WIDTH-1];
`endif
      end
      M_ROR: begin
        step_val = {q_q[0], q_q[WIDTH-1:1]};
`ifdef SHIFT_CARRY_EN
        step_cy  = q_q[0];
`endif
      end
      M_SLL: begin
        step_val = {q_q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_CARRY_EN
        step_cy  = q_q[WIDTH-1];
`endif
      end
      M_SRL: begin
        step_val = {1'b0, q_q[WIDTH-1:1]};
`ifdef SHIFT_CARRY_EN
        step_cy  = q_q[0];
`endif
      end
      M_SRA: begin
        step_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
`ifdef SHIFT_CARRY_EN
        step_cy  = q_q[0];
`endif
      end
`ifdef SHIFT_CARRY_EN
      M_RCL: begin
        step_val = {q_q[WIDTH-2:0], carry_q};
        step_cy  = q_q[WIDTH-1];
      end
      M_RCR: begin
        step_val = {carry_q, q_q[WIDTH-1:1]};
        step_cy  = q_q[0];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
`ifdef SHIFT_CARRY_EN
    carry_d = carry_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          q_d     = sel ? a : b;
          mode_d  = mode;
          rem_d   = count;
          state_d = (count == '0) ? ST_DONE : ST_RUN;
`ifdef SHIFT_CARRY_EN
          carry_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        q_d   = step_val;
        rem_d = rem_q - CNT_W'(1);
`ifdef SHIFT_CARRY_EN
        carry_d = step_cy;
`endif
        if (rem_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFT_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SHIFT_CARRY_EN
  assign carry = carry_q;
`endif

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Self-checking bench for shift_rotate_seq (WIDTH=8, CNT_W=4): directed vectors plus
// randomized operations compared against an arithmetic reference model.
module tb_shift_rotate_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sel;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] q;
  logic       busy;
  logic       done;
`ifdef SHIFT_CARRY_EN
  logic       carry;
`endif

  int checks   = 0;
  int failures = 0;

  shift_rotate_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .mode  (mode),
    .count (count),
    .q     (q),
    .busy  (busy),
    .done  (done)
`ifdef SHIFT_CARRY_EN
    ,
    .carry (carry)
`endif
  );

  always #5 clk = ~clk;

  // Result of n steps computed in closed form rather than step by step.
  function automatic void model(input logic [7:0] x, input logic [2:0] m, input int n,
                                output logic [7:0] r, output logic c);
    int k;
    logic [8:0] v;
    r = x;
    c = 1'b0;
    if (n == 0) return;
    case (m)
      3'd0: begin
        k = n % 8;
        r = (k == 0) ? x : 8'((16'(x) << k) | (16'(x) >> (8 - k)));
        c = r[0];
      end
      3'd1: begin
        k = n % 8;
        r = (k == 0) ? x : 8'((16'(x) >> k) | (16'(x) << (8 - k)));
        c = r[7];
      end
      3'd2: begin
        r = (n >= 8) ? 8'h00 : 8'(16'(x) << n);
        c = (n <= 8) ? x[8-n] : 1'b0;
      end
      3'd3: begin
        r = (n >= 8) ? 8'h00 : 8'(x >> n);
        c = (n <= 8) ? x[n-1] : 1'b0;
      end
      3'd4: begin
        r = (n >= 8) ? {8{x[7]}} : 8'($signed(x) >>> n);
        c = (n <= 8) ? x[n-1] : x[7];
      end
`ifdef SHIFT_CARRY_EN
      3'd6: begin
        k = n % 9;
        v = {1'b0, x};
        if (k != 0) v = 9'((18'(v) << k) | (18'(v) >> (9 - k)));
        r = v[7:0];
        c = v[8];
      end
      3'd7: begin
        k = n % 9;
        v = {1'b0, x};
        if (k != 0) v = 9'((18'(v) >> k) | (18'(v) << (9 - k)));
        r = v[7:0];
        c = v[8];
      end
`endif
      default: ;
    endcase
  endfunction

  // Issue one start, scramble the inputs afterwards, then wait (bounded) for done.
  task automatic do_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] m, input int n, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; sel = s; a = av; b = bv; mode = m; count = 4'(n);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = 3'($urandom); count = 4'($urandom);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; a = 8'h00; b = 8'h00; mode = 3'd0; count = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%h busy=%b done=%b, required q=00 busy=0 done=0", q, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  typedef struct {logic s; logic [7:0] av; logic [7:0] bv; logic [2:0] m; int n; logic [7:0] exp;} vec_t;

  task automatic test_directed();
    vec_t tbl[7];
    int lat, bc;
    tbl[0] = '{1'b1, 8'h81, 8'h00, 3'd0, 1,  8'h03};
    tbl[1] = '{1'b0, 8'h00, 8'h01, 3'd1, 3,  8'h20};
    tbl[2] = '{1'b0, 8'h00, 8'h80, 3'd4, 3,  8'hF0};
    tbl[3] = '{1'b0, 8'h00, 8'h80, 3'd4, 15, 8'hFF};
    tbl[4] = '{1'b0, 8'h00, 8'h80, 3'd3, 15, 8'h00};
    tbl[5] = '{1'b1, 8'h5A, 8'h00, 3'd0, 0,  8'h5A};
    tbl[6] = '{1'b1, 8'h5A, 8'h00, 3'd0, 9,  8'hB4};
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].s, tbl[i].av, tbl[i].bv, tbl[i].m, tbl[i].n, lat, bc);
      checks++;
      if (q !== tbl[i].exp || lat !== tbl[i].n + 1 || bc !== tbl[i].n) begin
        failures++;
        $display("FAIL directed[%0d]: q=%h lat=%0d busy_cycles=%0d, required q=%h lat=%0d busy_cycles=%0d",
                 i, q, lat, bc, tbl[i].exp, tbl[i].n + 1, tbl[i].n);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q !== 8'hB4 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_hold: q=%h done=%b busy=%b, required q=b4 done=1 busy=0", q, done, busy);
    end
  endtask

`ifdef SHIFT_CARRY_EN
  task automatic test_carry();
    int lat, bc;
    do_op(1'b1, 8'h80, 8'h00, 3'd2, 1, lat, bc);
    checks++;
    if (q !== 8'h00 || carry !== 1'b1) begin
      failures++;
      $display("FAIL carry_sll: q=%h carry=%b, required q=00 carry=1", q, carry);
    end
    do_op(1'b1, 8'h00, 8'h00, 3'd6, 1, lat, bc);
    checks++;
    if (q !== 8'h00 || carry !== 1'b0) begin
      failures++;
      $display("FAIL carry_rcl1: q=%h carry=%b, required q=00 carry=0", q, carry);
    end
    do_op(1'b1, 8'h80, 8'h00, 3'd6, 2, lat, bc);
    checks++;
    if (q !== 8'h01 || carry !== 1'b0) begin
      failures++;
      $display("FAIL carry_rcl2: q=%h carry=%b, required q=01 carry=0", q, carry);
    end
  endtask
`endif

  task automatic test_random();
    int lat, bc, n;
    logic s;
    logic [7:0] av, bv, er;
    logic [2:0] m;
    logic ec;
    for (int i = 0; i < 60; i++) begin
      s  = 1'($urandom);
      av = 8'($urandom);
      bv = 8'($urandom);
      m  = 3'($urandom);
      n  = int'($urandom_range(0, 15));
      model(s ? av : bv, m, n, er, ec);
      do_op(s, av, bv, m, n, lat, bc);
      checks++;
      if (q !== er || lat !== n + 1 || bc !== n) begin
        failures++;
        $display("FAIL random[%0d] mode=%0d n=%0d: q=%h lat=%0d busy_cycles=%0d, required q=%h lat=%0d busy_cycles=%0d",
                 i, m, n, q, lat, bc, er, n + 1, n);
      end
`ifdef SHIFT_CARRY_EN
      checks++;
      if (carry !== ec) begin
        failures++;
        $display("FAIL random_carry[%0d] mode=%0d n=%0d: carry=%b, required %b", i, m, n, carry, ec);
      end
`endif
    end
  endtask

  task automatic test_start_in_run();
    int lat;
    @(negedge clk);
    start = 1'b1; sel = 1'b1; a = 8'h01; b = 8'h00; mode = 3'd0; count = 4'd5;
    @(negedge clk);
    start = 1'b1; sel = 1'b1; a = 8'hFF; b = 8'hFF; mode = 3'd3; count = 4'd0;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (q !== 8'h20 || lat !== 6) begin
      failures++;
      $display("FAIL start_in_run: q=%h lat=%0d, required q=20 lat=6", q, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; sel = 1'b0; a = 8'h00; b = 8'hFF; mode = 3'd0; count = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_busy: busy=%b, required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: q=%h busy=%b done=%b, required q=00 busy=0 done=0", q, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: q=%h busy=%b done=%b, required q=00 busy=0 done=0", q, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef SHIFT_CARRY_EN
    test_carry();
`endif
    test_random();
    test_start_in_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
